// File: rtl/sink_vldrdy_chk.sv
// Valid/ready sink with a configurable ready pattern and a protocol checker.
// Counts transfers, stalls and a data checksum; flags valid drops and data changes while stalled.
module sink_vldrdy_chk #(
  parameter int          DWIDTH    = 8,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_mode,
  input  logic [7:0]        cfg_period,
  input  logic [7:0]        cfg_duty,
  input  logic              dst_val,
  output logic              dst_rdy,
  input  logic [DWIDTH-1:0] dst_data,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  checksum,
  output logic              err_val_drop,
  output logic              err_data_chg,
  output logic              err_sticky
);

  // Handshake: a beat is accepted on a rising edge where cfg_en, dst_val and dst_rdy are all 1;
  // once dst_val is raised without dst_rdy, the source must hold dst_val and dst_data until accepted.

  typedef enum logic [1:0] {
    MODE_ALWAYS   = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RANDOM   = 2'd2,
    MODE_NEVER    = 2'd3
  } mode_e;

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS = 16'hB400;

  mode_e              mode;
  logic [CNT_W-1:0]   data_ext;
  logic               xfer, stall, mode_chg, rdy_nxt;

  logic               rdy_q, rdy_d;
  logic               init_q, init_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         phase_q, phase_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   xfer_q, xfer_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   sum_q, sum_d;
  logic               pend_q, pend_d;
  logic [DWIDTH-1:0]  data_q, data_d;
  logic               vdrop_q, vdrop_d;
  logic               dchg_q, dchg_d;
  logic               sticky_q, sticky_d;

  assign mode = mode_e'(cfg_mode);

  if (DWIDTH >= CNT_W) begin : g_trunc
    assign data_ext = dst_data[CNT_W-1:0];
  end else begin : g_zext
    assign data_ext = {{(CNT_W-DWIDTH){1'b0}}, dst_data};
  end

  always_comb begin
    xfer     = cfg_en & dst_val & rdy_q;
    stall    = cfg_en & dst_val & ~rdy_q;
    mode_chg = (cfg_mode != mode_q);
    rdy_nxt  = 1'b0;
    phase_d  = phase_q;
    lfsr_d   = lfsr_q;
    xfer_d   = xfer_q;
    stall_d  = stall_q;
    sum_d    = sum_q;
    data_d   = data_q;
    mode_d   = cfg_mode;
    init_d   = 1'b1;

    unique case (mode)
      MODE_ALWAYS:   rdy_nxt = 1'b1;
      MODE_PERIODIC: rdy_nxt = (phase_q < cfg_duty);
      MODE_RANDOM:   rdy_nxt = lfsr_q[0];
      MODE_NEVER:    rdy_nxt = 1'b0;
      default:       rdy_nxt = 1'b0;
    endcase
    // init_q keeps ready low for the first edge after reset release.
    rdy_d = cfg_en & init_q & rdy_nxt;

    if (cfg_en) begin
      if (mode_chg) begin
        phase_d = 8'd0;
      end else if (mode == MODE_PERIODIC) begin
        phase_d = (phase_q >= cfg_period) ? 8'd0 : phase_q + 8'd1;
      end
      if (mode == MODE_RANDOM) begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
      end
      data_d = dst_data;
    end

    if (xfer) begin
      xfer_d = xfer_q + CNT_W'(1);
      sum_d  = sum_q + data_ext;
    end
    if (stall && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    pend_d   = stall;
    vdrop_d  = cfg_en & pend_q & ~dst_val;
    dchg_d   = cfg_en & pend_q & dst_val & (dst_data != data_q);
    sticky_d = sticky_q | vdrop_d | dchg_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      init_q   <= 1'b0;
      mode_q   <= 2'd0;
      phase_q  <= 8'd0;
      lfsr_q   <= SEED;
      xfer_q   <= '0;
      stall_q  <= '0;
      sum_q    <= '0;
      pend_q   <= 1'b0;
      data_q   <= '0;
      vdrop_q  <= 1'b0;
      dchg_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      rdy_q    <= rdy_d;
      init_q   <= init_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
      xfer_q   <= xfer_d;
      stall_q  <= stall_d;
      sum_q    <= sum_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      vdrop_q  <= vdrop_d;
      dchg_q   <= dchg_d;
      sticky_q <= sticky_d;
    end
  end

  assign dst_rdy      = rdy_q;
  assign xfer_cnt     = xfer_q;
  assign stall_cnt    = stall_q;
  assign checksum     = sum_q;
  assign err_val_drop = vdrop_q;
  assign err_data_chg = dchg_q;
  assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_sink_vldrdy_chk.sv
// Bench for sink_vldrdy_chk: directed vectors, a cycle-level reference model feeding an
// expected queue, a per-cycle compare process and literal checks on the key scenarios.
module tb_sink_vldrdy_chk;

  localparam int DWIDTH = 8;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic        rdy;
    logic        vdrop;
    logic        dchg;
    logic        sticky;
    logic [31:0] xfer;
    logic [31:0] stall;
    logic [31:0] sum;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_en = 1'b0;
  logic [1:0]        cfg_mode = 2'd0;
  logic [7:0]        cfg_period = 8'd0;
  logic [7:0]        cfg_duty = 8'd0;
  logic              dst_val = 1'b0;
  logic              dst_rdy;
  logic [DWIDTH-1:0] dst_data = '0;
  logic [CNT_W-1:0]  xfer_cnt, stall_cnt, checksum;
  logic              err_val_drop, err_data_chg, err_sticky;

  always #5 clk = ~clk;

  sink_vldrdy_chk #(.DWIDTH(DWIDTH), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .dst_val(dst_val),
    .dst_rdy(dst_rdy), .dst_data(dst_data), .xfer_cnt(xfer_cnt),
    .stall_cnt(stall_cnt), .checksum(checksum), .err_val_drop(err_val_drop),
    .err_data_chg(err_data_chg), .err_sticky(err_sticky)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_vdrop = 0;
  int cnt_dchg  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // ---------------- reference model ----------------
  logic        m_rdy = 1'b0, m_vdrop = 1'b0, m_dchg = 1'b0, m_sticky = 1'b0;
  logic [31:0] m_xfer = '0, m_stall = '0, m_sum = '0;
  logic        m_pend = 1'b0, m_init = 1'b0;
  logic [7:0]  m_data = '0;
  logic [1:0]  m_prev = 2'd0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_ticks = 0;
  logic [EXP_W-1:0] exp_q[$];

  always @(posedge clk) begin
    logic v, c, nr;
    logic [7:0] ph;
    exp_t e;
    if (rst) begin
      m_rdy = 0; m_vdrop = 0; m_dchg = 0; m_sticky = 0;
      m_xfer = 0; m_stall = 0; m_sum = 0; m_pend = 0; m_init = 0;
      m_data = 0; m_prev = 0; m_lfsr = 16'hACE1; m_ticks = 0;
    end else begin
      v = cfg_en && m_pend && !dst_val;
      c = cfg_en && m_pend && dst_val && (dst_data != m_data);
      if (cfg_en && dst_val && m_rdy) begin
        m_xfer = m_xfer + 1;
        m_sum  = m_sum + {24'd0, dst_data};
      end
      if (cfg_en && dst_val && !m_rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      m_vdrop = v; m_dchg = c; m_sticky = m_sticky | v | c;
      m_pend = cfg_en && dst_val && !m_rdy;
      if (cfg_en) m_data = dst_data;
      // Periodic phase is the count of enabled mode-1 cycles since the mode was entered.
      ph = 8'(m_ticks % (int'(cfg_period) + 1));
      case (cfg_mode)
        2'd0:    nr = 1'b1;
        2'd1:    nr = (ph < cfg_duty);
        2'd2:    nr = m_lfsr[0];
        default: nr = 1'b0;
      endcase
      if (!cfg_en || !m_init) nr = 1'b0;
      if (cfg_en) begin
        if (cfg_mode != m_prev) m_ticks = 0;
        else if (cfg_mode == 2'd1) m_ticks++;
        if (cfg_mode == 2'd2) m_lfsr = lfsr_next(m_lfsr);
      end
      m_prev = cfg_mode;
      m_init = 1'b1;
      m_rdy  = nr;
    end
    e = '{rdy: m_rdy, vdrop: m_vdrop, dchg: m_dchg, sticky: m_sticky,
          xfer: m_xfer, stall: m_stall, sum: m_sum};
    exp_q.push_back(e);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q: got empty queue, expected an entry (t=%0t)", $time);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check("dst_rdy", 64'(dst_rdy), 64'(e.rdy));
      check("xfer_cnt", 64'(xfer_cnt), 64'(e.xfer));
      check("stall_cnt", 64'(stall_cnt), 64'(e.stall));
      check("checksum", 64'(checksum), 64'(e.sum));
      check("err_val_drop", 64'(err_val_drop), 64'(e.vdrop));
      check("err_data_chg", 64'(err_data_chg), 64'(e.dchg));
      check("err_sticky", 64'(err_sticky), 64'(e.sticky));
    end
    cnt_vdrop += int'(err_val_drop);
    cnt_dchg  += int'(err_data_chg);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic [1:0] mode, input logic val,
                      input logic [7:0] data);
    @(negedge clk);
    #1;
    cfg_en = en; cfg_mode = mode; dst_val = val; dst_data = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; cfg_en = 1'b0; dst_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cnt_vdrop = 0;
    cnt_dchg  = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] s;
    rst = 1'b1;

    // Pin the LFSR polynomial: ACE1 -> E270 -> 7138 -> 389C -> 1C4E -> 0E27 -> B313.
    s = 16'hACE1;
    for (int i = 0; i < 6; i++) s = lfsr_next(s);
    check("lfsr_ref_6", 64'(s), 64'h0000_0000_0000_B313);

    do_reset();
    check("rst_rdy", 64'(dst_rdy), 64'd0);
    check("rst_xfer", 64'(xfer_cnt), 64'd0);

    // Mode 0: ten beats 1..10.
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 1; i <= 10; i++) step(1, 0, 1, 8'(i));
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("m0_xfer", 64'(xfer_cnt), 64'd10);
    check("m0_sum", 64'(checksum), 64'd55);
    check("m0_stall", 64'(stall_cnt), 64'd0);
    check("m0_sticky", 64'(err_sticky), 64'd0);

    // Mode 1: period 4, one ready cycle per period.
    do_reset();
    cfg_period = 8'd3; cfg_duty = 8'd1;
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 8'h42);
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    check("m1_xfer", 64'(xfer_cnt), 64'd5);
    check("m1_stall", 64'(stall_cnt), 64'd15);

    // Mode 1 boundaries: duty above period -> always ready; duty 0 -> never ready.
    step(1, 0, 0, 8'h00);
    cfg_period = 8'd2; cfg_duty = 8'd5;
    for (int i = 0; i < 6; i++) step(1, 1, 1, 8'(i + 3));
    check("m1_duty_gt_period", 64'(dst_rdy), 64'd1);
    cfg_duty = 8'd0;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h00);
    check("m1_duty_zero", 64'(dst_rdy), 64'd0);

    // Mode 3: data changes while stalled.
    do_reset();
    step(1, 3, 0, 8'h00);
    step(1, 3, 0, 8'h00);
    step(1, 3, 1, 8'h5A);
    step(1, 3, 1, 8'h5A);
    step(1, 3, 1, 8'hA5);
    step(1, 3, 1, 8'hA5);
    step(0, 3, 1, 8'hA5);
    step(0, 3, 0, 8'h00);
    step(0, 3, 0, 8'h00);
    check("m3_dchg_pulses", 64'(cnt_dchg), 64'd1);
    check("m3_vdrop_pulses", 64'(cnt_vdrop), 64'd0);
    check("m3_sticky", 64'(err_sticky), 64'd1);
    check("m3_xfer", 64'(xfer_cnt), 64'd0);

    // Mode 3: valid withdrawn, then a stall ended by cfg_en=0.
    do_reset();
    step(1, 3, 0, 8'h00);
    step(1, 3, 1, 8'h11);
    step(1, 3, 1, 8'h11);
    step(1, 3, 0, 8'h00);
    step(1, 3, 0, 8'h00);
    step(1, 3, 1, 8'h22);
    step(1, 3, 1, 8'h22);
    step(0, 3, 1, 8'h22);
    step(0, 3, 0, 8'h00);
    step(0, 3, 0, 8'h00);
    check("m3_vdrop_once", 64'(cnt_vdrop), 64'd1);
    check("m3_no_dchg", 64'(cnt_dchg), 64'd0);
    check("m3_sticky2", 64'(err_sticky), 64'd1);

    // Changed data accepted while flagged: ready alternates 1,0.
    do_reset();
    cfg_period = 8'd1; cfg_duty = 8'd1;
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 8'(8'h10 + i));
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    check("alt_xfer", 64'(xfer_cnt), 64'd4);
    check("alt_sum", 64'(checksum), 64'd80);
    check("alt_stall", 64'(stall_cnt), 64'd4);
    check("alt_dchg_pulses", 64'(cnt_dchg), 64'd4);

    // Mode 2: 1000 cycles of held valid against the LFSR.
    do_reset();
    step(0, 2, 0, 8'h00);
    step(0, 2, 0, 8'h00);
    step(1, 2, 1, 8'h33);
    step(1, 2, 1, 8'h33);
    check("m2_rdy_first", 64'(dst_rdy), 64'd1);
    step(1, 2, 1, 8'h33);
    check("m2_rdy_second", 64'(dst_rdy), 64'd0);
    repeat (997) step(1, 2, 1, 8'h33);
    step(0, 2, 0, 8'h00);
    step(0, 2, 0, 8'h00);
    check("m2_total", 64'(xfer_cnt) + 64'(stall_cnt), 64'd1000);
    check("m2_sticky", 64'(err_sticky), 64'd0);

    // Mode 0: reset in the middle of a stream.
    do_reset();
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 1; i <= 4; i++) step(1, 0, 1, 8'(i));
    step(1, 0, 1, 8'h07);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_xfer", 64'(xfer_cnt), 64'd0);
    check("mid_rst_rdy", 64'(dst_rdy), 64'd0);
    check("mid_rst_sum", 64'(checksum), 64'd0);
    #1;
    rst = 1'b0;
    step(1, 0, 1, 8'h07);
    check("rel_rdy_edge1", 64'(dst_rdy), 64'd0);
    step(1, 0, 1, 8'h07);
    check("rel_rdy_edge2", 64'(dst_rdy), 64'd1);
    step(1, 0, 1, 8'h07);
    step(1, 0, 1, 8'h07);
    step(1, 0, 1, 8'h07);
    check("rel_xfer", 64'(xfer_cnt), 64'd3);
    check("rel_stall", 64'(stall_cnt), 64'd2);
    check("rel_sum", 64'(checksum), 64'd21);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
